hdlc_rx_deframer: RTL and testbench

//  Clk_100m-domain HDLC receiver; bit-level inverse of hdlctra. Oversamples async RS485 line clock/data,

---
 rtl/hdlc_pkg.sv | 27 ++
 rtl/hdlc_rx_sync.sv | 35 +++
 rtl/hdlc_rx_deframer.sv | 155 +++++++++++++++
 tb/tb_hdlc_rx_deframer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// Shared constants, status codes, FSM state type and the CRC-16/X.25 step
// used by the HDLC receive path.
package hdlc_pkg;

  localparam logic [7:0]  FLAG_BYTE  = 8'h7E;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_R = 16'h8408;
  localparam logic [15:0] CRC_GOOD   = 16'hF0B8;

  localparam logic [2:0] ST_GOOD    = 3'b000;
  localparam logic [2:0] ST_CRC_ERR = 3'b001;
  localparam logic [2:0] ST_ALIGN   = 3'b010;
  localparam logic [2:0] ST_ABORT   = 3'b100;

  typedef enum logic [1:0] {S_HUNT, S_OPEN, S_DATA, S_CLOSE} rx_state_t;

  // Reflected CRC-16 over one octet, LSB first, matching the line bit order.
  function automatic logic [15:0] crc16_x25_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/hdlc_rx_sync.sv
// Brings the async line clock/data into clk_100m and emits one bit_vld pulse
// per rising line-clock edge, with the data sampled alongside it.
module hdlc_rx_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk_100m,
  input  logic rst,
  input  logic clkr,
  input  logic datar,
  output logic bit_vld,
  output logic bit_val
);

  logic [SYNC_STG-1:0] clk_sync;
  logic [SYNC_STG-1:0] dat_sync;
  logic                clk_prev;

  // Both lines travel through equal-length chains so data stays aligned with its clock edge.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
      bit_vld  <= 1'b0;
      bit_val  <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STG-2:0], clkr};
      dat_sync <= {dat_sync[SYNC_STG-2:0], datar};
      clk_prev <= clk_sync[SYNC_STG-1];
      bit_vld  <= clk_sync[SYNC_STG-1] & ~clk_prev;
      bit_val  <= dat_sync[SYNC_STG-1];
    end
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero-bit removal, LSB-first
// octet assembly into the rx RAM, FCS check and DSP interrupt.
module hdlc_rx_deframer
  import hdlc_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int SYNC_STG  = 2,
  parameter int MIN_BYTES = 4
) (
  input  logic              clk_100m,
  input  logic              rst,
  input  logic              clkr,
  input  logic              datar,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              rx_busy,
  output logic              rx_done,
  output logic [ADDR_W:0]   rx_len,
  output logic [2:0]        rx_status,
  output logic              irq,
  input  logic              irq_ack
);

  localparam int              MAX_BYTES = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] MAX_CNT   = (ADDR_W + 1)'(MAX_BYTES);
  localparam logic [ADDR_W:0] MIN_CNT   = (ADDR_W + 1)'(MIN_BYTES);

  logic            bit_vld, bit_val;
  rx_state_t       state;
  logic [2:0]      ones_cnt, bit_cnt;
  logic [6:0]      shift;
  logic [ADDR_W:0] byte_cnt;
  logic [15:0]     crc;
  logic            overflow;

  logic            is_abort, is_stuff, is_flag, is_data, octet_done;
  logic [7:0]      octet;
  logic [2:0]      close_status;

  hdlc_rx_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk_100m (clk_100m),
    .rst      (rst),
    .clkr     (clkr),
    .datar    (datar),
    .bit_vld  (bit_vld),
    .bit_val  (bit_val)
  );

  always_comb begin
    is_abort   = bit_vld &&  bit_val && (ones_cnt == 3'd6);
    is_stuff   = bit_vld && !bit_val && (ones_cnt == 3'd5);
    is_flag    = bit_vld && !bit_val && (ones_cnt == 3'd6);
    is_data    = bit_vld && !is_abort && !is_stuff && !is_flag;
    octet      = {bit_val, shift};
    octet_done = is_data && (bit_cnt == 3'd7) && (state == S_OPEN || state == S_DATA);
    // The closing flag shifts 7 bits as data, so an aligned frame ends at bit_cnt 7.
    close_status = ST_GOOD;
    if (overflow)                 close_status = ST_ABORT;
    else if (bit_cnt != 3'd7)     close_status = ST_ALIGN;
    else if (byte_cnt < MIN_CNT)  close_status = ST_ALIGN;
    else if (crc != CRC_GOOD)     close_status = ST_CRC_ERR;
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state     <= S_HUNT;
      ones_cnt  <= 3'd0;
      bit_cnt   <= 3'd0;
      shift     <= 7'd0;
      byte_cnt  <= '0;
      crc       <= CRC_INIT;
      overflow  <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 8'd0;
      rx_busy   <= 1'b0;
      rx_done   <= 1'b0;
      rx_len    <= '0;
      rx_status <= 3'd0;
      irq       <= 1'b0;
    end else begin
      ram_we  <= 1'b0;
      rx_done <= 1'b0;
      if (irq_ack) irq <= 1'b0;
      if (bit_vld)
        ones_cnt <= bit_val ? ((ones_cnt == 3'd7) ? 3'd7 : ones_cnt + 3'd1) : 3'd0;
      if (is_data && (state == S_OPEN || state == S_DATA)) begin
        shift   <= octet[7:1];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (octet_done) begin
        if (byte_cnt == MAX_CNT) begin
          overflow <= 1'b1;
        end else begin
          ram_we    <= 1'b1;
          ram_addr  <= byte_cnt[ADDR_W-1:0];
          ram_wdata <= octet;
          crc       <= crc16_x25_byte(crc, octet);
          byte_cnt  <= byte_cnt + (ADDR_W + 1)'(1);
        end
      end
      // Flag bits seen while OPEN are discarded; the first full octet starts the frame.
      case (state)
        S_HUNT: begin
          if (is_flag) begin
            state   <= S_OPEN;
            bit_cnt <= 3'd0;
          end
        end
        S_OPEN: begin
          if (is_abort) begin
            state   <= S_HUNT;
            bit_cnt <= 3'd0;
          end else if (is_flag) begin
            bit_cnt <= 3'd0;
          end else if (octet_done) begin
            state   <= S_DATA;
            rx_busy <= 1'b1;
          end
        end
        S_DATA: begin
          if (is_abort) begin
            state     <= S_HUNT;
            rx_done   <= 1'b1;
            rx_status <= ST_ABORT;
            rx_len    <= byte_cnt;
            irq       <= 1'b1;
            rx_busy   <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
            crc       <= CRC_INIT;
            overflow  <= 1'b0;
          end else if (is_flag) begin
            state <= S_CLOSE;
          end
        end
        S_CLOSE: begin
          state     <= S_OPEN;
          rx_done   <= 1'b1;
          rx_status <= close_status;
          rx_len    <= byte_cnt;
          irq       <= 1'b1;
          rx_busy   <= 1'b0;
          bit_cnt   <= 3'd0;
          byte_cnt  <= '0;
          crc       <= CRC_INIT;
          overflow  <= 1'b0;
        end
        default: state <= S_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Drives bit-stuffed HDLC frames on the line and checks RAM writes, length,
// status and irq against a frame-level model of the receiver rules.
module tb_hdlc_rx_deframer;
  import hdlc_pkg::*;

  localparam int ADDR_W    = 9;
  localparam int MAX_BYTES = 512;
  localparam int HALF      = 5;

  logic              clk_100m, rst, clkr, datar, irq_ack;
  logic              ram_we, rx_busy, rx_done, irq;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [ADDR_W:0]   rx_len;
  logic [2:0]        rx_status;

  hdlc_rx_deframer #(.ADDR_W(ADDR_W), .SYNC_STG(2), .MIN_BYTES(4)) dut (
    .clk_100m  (clk_100m),
    .rst       (rst),
    .clkr      (clkr),
    .datar     (datar),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .rx_busy   (rx_busy),
    .rx_done   (rx_done),
    .rx_len    (rx_len),
    .rx_status (rx_status),
    .irq       (irq),
    .irq_ack   (irq_ack)
  );

  initial clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  int assn_cnt = 0;
  int fail_cnt = 0;
  int done_cnt = 0;
  int tx_ones  = 0;
  bit drop_ack_on_done = 1'b0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [7:0]        wr_data_q[$];
  logic [7:0]        frame_q[$];

  // Record every RAM write and frame completion, sampled mid-cycle.
  always @(negedge clk_100m) begin
    if (ram_we === 1'b1) begin
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_wdata);
    end
    if (rx_done === 1'b1) done_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assn_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycle();
    @(negedge clk_100m);
    if (drop_ack_on_done && rx_done === 1'b1) irq_ack = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    clkr  = 1'b0;
    datar = b;
    repeat (HALF) wait_cycle();
    clkr = 1'b1;
    repeat (HALF) wait_cycle();
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = FLAG_BYTE;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    tx_ones = 0;
  endtask

  task automatic send_data_bit(input logic b);
    send_bit(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        send_bit(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_data_bit(d[i]);
  endtask

  function automatic logic [15:0] crc_over(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ frame_q[k][i];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic logic [2:0] exp_status(input bit aligned);
    int n;
    n = frame_q.size();
    if (n > MAX_BYTES) return 3'b100;
    if (!aligned) return 3'b010;
    if (n < 4) return 3'b010;
    if (crc_over(n) != 16'hF0B8) return 3'b001;
    return 3'b000;
  endfunction

  task automatic fill_random(input int n);
    frame_q.delete();
    repeat (n) frame_q.push_back(8'($urandom));
  endtask

  task automatic append_fcs(input bit corrupt);
    logic [15:0] fcs;
    int          last;
    fcs = ~crc_over(frame_q.size());
    frame_q.push_back(fcs[7:0]);
    frame_q.push_back(fcs[15:8]);
    if (corrupt) begin
      last = frame_q.size() - 1;
      frame_q[last] = frame_q[last] ^ 8'(1 << $urandom_range(0, 7));
    end
  endtask

  task automatic apply_stimulus(input string tag, input int extra_flags, input int stray,
                                input bit check_data);
    int         dbase, wbase, n, nw;
    logic [2:0] es;
    dbase = done_cnt;
    wbase = wr_addr_q.size();
    n     = frame_q.size();
    es    = exp_status(stray == 0);
    repeat (extra_flags) send_flag();
    send_flag();
    foreach (frame_q[k]) send_byte(frame_q[k]);
    for (int i = 0; i < stray; i++) send_data_bit(1'($urandom));
    send_flag();
    for (int k = 0; k < 200 && done_cnt == dbase; k++) wait_cycle();
    repeat (20) wait_cycle();
    check_output({tag, "_done"}, done_cnt - dbase, 1);
    check_output({tag, "_status"}, rx_status, es);
    check_output({tag, "_irq"}, irq, 1);
    if (check_data) begin
      nw = (n > MAX_BYTES) ? MAX_BYTES : n;
      check_output({tag, "_len"}, rx_len, nw);
      check_output({tag, "_nwrites"}, wr_addr_q.size() - wbase, nw);
      for (int k = 0; k < nw && (wbase + k) < wr_addr_q.size(); k++) begin
        check_output($sformatf("%s_addr%0d", tag, k), wr_addr_q[wbase + k], k);
        check_output($sformatf("%s_data%0d", tag, k), wr_data_q[wbase + k], frame_q[k]);
      end
    end
  endtask

  initial begin
    int dbase, wbase;
    string s;

    rst = 1'b1; clkr = 1'b0; datar = 1'b0; irq_ack = 1'b0;
    repeat (4) @(negedge clk_100m);
    check_output("reset_outputs", {ram_we, rx_busy, rx_done, rx_len, rx_status, irq}, 0);
    rst = 1'b0;
    repeat (3) wait_cycle();
    check_output("post_reset_outputs", {ram_we, rx_busy, rx_done, rx_len, rx_status, irq}, 0);

    // Reference frame "123456789" with its correct FCS.
    s = "123456789";
    frame_q.delete();
    for (int i = 0; i < 9; i++) frame_q.push_back(s[i]);
    frame_q.push_back(8'h6E);
    frame_q.push_back(8'h90);
    apply_stimulus("check_frame", 0, 0, 1'b1);
    check_output("check_frame_status_good", rx_status, 3'b000);
    irq_ack = 1'b1; wait_cycle(); irq_ack = 1'b0; wait_cycle();
    check_output("irq_ack_clears", irq, 0);

    frame_q[10] = 8'h90;
    frame_q[9]  = 8'h6F;
    apply_stimulus("bad_fcs", 0, 0, 1'b1);
    check_output("bad_fcs_status", rx_status, 3'b001);

    // Heavy stuffing after back-to-back flags.
    frame_q.delete();
    frame_q.push_back(8'h3F);
    repeat (3) begin frame_q.push_back(8'h3F); frame_q.push_back(8'h7C); end
    append_fcs(1'b0);
    apply_stimulus("stuffed", 2, 0, 1'b1);

    // Abort after two octets.
    dbase = done_cnt; wbase = wr_addr_q.size();
    send_flag(); send_byte(8'h12); send_byte(8'h34);
    check_output("abort_busy_mid", rx_busy, 1);
    repeat (9) send_bit(1'b1);
    tx_ones = 0;
    repeat (20) wait_cycle();
    check_output("abort_done", done_cnt - dbase, 1);
    check_output("abort_status", rx_status, 3'b100);
    check_output("abort_len", rx_len, 2);
    check_output("abort_nwrites", wr_addr_q.size() - wbase, 2);
    check_output("abort_busy_end", rx_busy, 0);
    fill_random(5); append_fcs(1'b0);
    apply_stimulus("after_abort", 0, 0, 1'b1);

    frame_q.delete();
    repeat (3) frame_q.push_back(8'($urandom));
    apply_stimulus("misaligned", 0, 3, 1'b0);

    frame_q.delete(); frame_q.push_back(8'h01); frame_q.push_back(8'h02);
    apply_stimulus("short", 0, 0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      fill_random($urandom_range(2, 12));
      append_fcs($urandom_range(0, 2) == 0);
      apply_stimulus($sformatf("rand%0d", r), 0, 0, 1'b1);
    end

    // irq_ack held over the rx_done update must not win.
    fill_random(6); append_fcs(1'b0);
    irq_ack = 1'b1; drop_ack_on_done = 1'b1;
    apply_stimulus("ack_collide", 0, 0, 1'b1);
    drop_ack_on_done = 1'b0; irq_ack = 1'b0;

    fill_random(520);
    apply_stimulus("overflow", 0, 0, 1'b1);

    // Reset in the middle of a frame.
    fill_random(3);
    dbase = done_cnt;
    send_flag();
    foreach (frame_q[k]) send_byte(frame_q[k]);
    check_output("midrst_busy_before", rx_busy, 1);
    rst = 1'b1; clkr = 1'b0;
    repeat (3) wait_cycle();
    rst = 1'b0; tx_ones = 0;
    wait_cycle();
    check_output("midrst_outputs", {ram_we, rx_busy, rx_done, rx_len, rx_status, irq}, 0);
    repeat (100) wait_cycle();
    check_output("midrst_no_done", done_cnt - dbase, 0);
    fill_random(4); append_fcs(1'b0);
    apply_stimulus("after_rst", 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assn_cnt, fail_cnt);
    $finish;
  end

endmodule
